// File: rtl/ram_arbiter_pkg.sv
// rtl/ram_arbiter_pkg.sv - shared state encoding and defaults for the RAM arbiter
`ifndef RAM_ARBITER_PKG_SV
`define RAM_ARBITER_PKG_SV
package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CPU  = 2'd1,
    VID  = 2'd2
  } arb_state_t;

  localparam int MAX_WAIT_DEFAULT = 4;

  // State records which port owned the RAM in the cycle just completed.
  function automatic arb_state_t next_state(input logic g0, input logic g1);
    if (g0) return CPU;
    if (g1) return VID;
    return IDLE;
  endfunction

endpackage
`endif

// File: rtl/dff.sv
// rtl/dff.sv - plain register with asynchronous active-low clear
module dff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) q <= '0;
    else          q <= d;
  end

endmodule

// File: rtl/rr_wait_counter.sv
// rtl/rr_wait_counter.sv - saturating 4-bit wait counter with clear and increment enables
module rr_wait_counter #(
  parameter logic [3:0] MAX = 4'd4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] count
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                  count <= 4'd0;
    else if (clr)                  count <= 4'd0;
    else if (inc && count != MAX)  count <= count + 4'd1;
  end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-port arbiter for a single-port RAM, CPU priority with scanout starvation guard
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 14,
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  arb_state_t        state_q;
  logic [3:0]        wait_cnt;
  logic              force1;
  logic [ADDR_W-1:0] addr_q;

  // Grants are masked by reset so nothing reaches the RAM while held in reset.
  always_comb begin
    force1 = req1 && (wait_cnt == MAX_W);
    gnt1   = reset_n && req1 && (force1 || !req0);
    gnt0   = reset_n && req0 && !gnt1;
  end

  rr_wait_counter #(.MAX(MAX_W)) u_wait (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (gnt1 || !req1),
    .inc     (req1 && !gnt1),
    .count   (wait_cnt)
  );

  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = addr_q;
    ram_wdata = wdata0;
    if (gnt0) begin
      ram_we    = we0;
      ram_addr  = addr0;
      ram_wdata = wdata0;
    end else if (gnt1) begin
      ram_we    = we1;
      ram_addr  = addr1;
      ram_wdata = wdata1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= next_state(gnt0, gnt1);
      addr_q  <= ram_addr;
    end
  end

  dff #(.W(1)) u_rv0 (.clk(clk), .reset_n(reset_n), .d(gnt0 && !we0), .q(rvalid0));
  dff #(.W(1)) u_rv1 (.clk(clk), .reset_n(reset_n), .d(gnt1 && !we1), .q(rvalid1));

  // Shared read bus only passes RAM data for the port that owned last cycle's read.
  always_comb begin
    rdata = '0;
    if ((rvalid0 && state_q == CPU) || (rvalid1 && state_q == VID))
      rdata = ram_rdata;
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - directed self-checking bench for ram_arbiter
module tb_ram_arbiter;
  import ram_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req0, req1, we0, we1;
  logic [13:0] addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [15:0] rdata;
  logic [13:0] ram_addr;
  logic        ram_we;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata;
  logic [15:0] mem [0:16383];

  int compared   = 0;
  int mismatched = 0;
  logic prev_g1, exp_g1;

  ram_arbiter dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req0      (req0),
    .req1      (req1),
    .we0       (we0),
    .we1       (we1),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .rvalid0   (rvalid0),
    .rvalid1   (rvalid1),
    .rdata     (rdata),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] <= 16'(i) ^ 16'hA5A5;
  end

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0; req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
    addr0 = 14'h3; addr1 = 14'h4; wdata0 = 16'h0; wdata1 = 16'h0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_gnt0", gnt0, 0);
    chk("rst_gnt1", gnt1, 0);
    chk("rst_rvalid0", rvalid0, 0);
    chk("rst_rvalid1", rvalid1, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_state", dut.state_q, IDLE);
    chk("rst_wait", dut.wait_cnt, 0);

    // release with a write already requested: grant in first cycle
    @(negedge clk);
    reset_n = 1'b1; req1 = 1'b0; req0 = 1'b1; we0 = 1'b1; addr0 = 14'h5; wdata0 = 16'h1234;
    #1;
    chk("wr0_gnt0", gnt0, 1);
    chk("wr0_gnt1", gnt1, 0);
    chk("wr0_ram_we", ram_we, 1);
    chk("wr0_ram_addr", ram_addr, 14'h5);
    chk("wr0_ram_wdata", ram_wdata, 16'h1234);
    @(negedge clk);
    we0 = 1'b0;
    #1;
    chk("rd0_gnt0", gnt0, 1);
    chk("rd0_ram_we", ram_we, 0);
    chk("rd0_ram_addr", ram_addr, 14'h5);
    chk("wr0_no_rvalid", rvalid0, 0);
    chk("rd0_state_cpu", dut.state_q, CPU);
    @(negedge clk);
    req0 = 1'b0;
    #1;
    chk("rd0_rvalid0", rvalid0, 1);
    chk("rd0_rdata", rdata, 16'h1234);
    chk("rd0_gnt0_off", gnt0, 0);
    chk("rd0_addr_hold", ram_addr, 14'h5);
    chk("rd0_rvalid1", rvalid1, 0);
    @(negedge clk);
    #1;
    chk("rd0_rvalid0_one", rvalid0, 0);
    chk("rd0_state_idle", dut.state_q, IDLE);

    // both ports requesting continuously: 0,0,0,0,1 repeating
    req0 = 1'b1; req1 = 1'b1; addr0 = 14'h10; addr1 = 14'h20;
    prev_g1 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      exp_g1 = (i % 5 == 4);
      chk("both_gnt1", gnt1, exp_g1);
      chk("both_gnt0", gnt0, !exp_g1);
      chk("both_wait", dut.wait_cnt, i % 5);
      if (i > 0) begin
        chk("both_rvalid1", rvalid1, prev_g1);
        chk("both_rvalid0", rvalid0, !prev_g1);
        chk("both_rdata", rdata, prev_g1 ? 16'hA585 : 16'hA5B5);
      end
      prev_g1 = exp_g1;
      @(negedge clk);
    end
    req0 = 1'b0; req1 = 1'b0;
    #1;
    chk("both_last_rvalid1", rvalid1, 1);
    chk("both_last_rdata", rdata, 16'hA585);

    // only port 1 reading: grant every cycle
    @(negedge clk);
    req1 = 1'b1; addr1 = 14'h1000;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("vid_gnt1", gnt1, 1);
      chk("vid_gnt0", gnt0, 0);
      chk("vid_ram_addr", ram_addr, 14'h1000);
      chk("vid_rvalid1", rvalid1, i > 0);
      if (i > 0) chk("vid_rdata", rdata, 16'hB5A5);
      @(negedge clk);
    end
    req1 = 1'b0;
    #1;
    chk("vid_last_rvalid1", rvalid1, 1);
    chk("vid_last_rdata", rdata, 16'hB5A5);
    chk("vid_gnt1_off", gnt1, 0);

    // port 1 write then read of the same address
    @(negedge clk);
    req1 = 1'b1; we1 = 1'b1; wdata1 = 16'hBEEF;
    #1;
    chk("wr1_gnt1", gnt1, 1);
    chk("wr1_ram_we", ram_we, 1);
    chk("wr1_ram_wdata", ram_wdata, 16'hBEEF);
    @(negedge clk);
    we1 = 1'b0;
    #1;
    chk("rd1_gnt1", gnt1, 1);
    chk("rd1_ram_we", ram_we, 0);
    chk("wr1_no_rvalid", rvalid1, 0);
    @(negedge clk);
    req1 = 1'b0;
    #1;
    chk("rd1_rvalid1", rvalid1, 1);
    chk("rd1_rdata", rdata, 16'hBEEF);

    // reset while a read is pending
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b0; addr0 = 14'h5;
    #1;
    chk("rstmid_gnt0", gnt0, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rstmid_gnt0_off", gnt0, 0);
    @(negedge clk);
    #1;
    chk("rstmid_rvalid0", rvalid0, 0);
    reset_n = 1'b1; req0 = 1'b0;
    @(negedge clk);
    #1;
    chk("rstmid_rvalid0_after", rvalid0, 0);
    chk("rstmid_state", dut.state_q, IDLE);
    chk("rstmid_wait", dut.wait_cnt, 0);
    chk("rstmid_ram_addr", ram_addr, 0);

    // idle cycles keep the last address and never write
    @(negedge clk);
    req0 = 1'b1; addr0 = 14'h77;
    #1;
    chk("idle_pre_gnt0", gnt0, 1);
    @(negedge clk);
    req0 = 1'b0; addr0 = 14'h3;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("idle_gnt0", gnt0, 0);
      chk("idle_gnt1", gnt1, 0);
      chk("idle_ram_we", ram_we, 0);
      chk("idle_ram_addr", ram_addr, 14'h77);
      @(negedge clk);
    end
    #1;
    chk("idle_state", dut.state_q, IDLE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
